gshare_pht_ctrl: RTL and testbench

//  Driver side of the pattern history table: owns the global history register (GHR), forms gshare

---
 rtl/gshare_pht_ctrl_if.sv | 38 +++
 rtl/gshare_pht_ctrl.sv | 130 +++++++++++++
 tb/tb_gshare_pht_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_pht_ctrl_if.sv
// gshare PHT controller bundle: fetch prediction handshake, branch
// resolve, status flags and the PHT read/write port.
interface gshare_pht_ctrl_if #(
    parameter int ENTRY = 8,
    parameter int PC_W  = 32
);
    logic             pred_req;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_ready;
    logic             pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             mispredict;
    logic             res_err;
    logic             init_done;
    logic [ENTRY-1:0] pht_read_index;
    logic [1:0]       pht_rdata;
    logic [ENTRY-1:0] pht_write_index;
    logic [1:0]       pht_cur_state;
    logic             pht_load;
    logic [1:0]       pht_wdata;

    modport slave (
        input  pred_req, pred_pc, res_valid, res_taken,
        input  pht_rdata, pht_cur_state,
        output pred_ready, pred_taken, mispredict, res_err,
        output init_done, pht_read_index, pht_write_index,
        output pht_load, pht_wdata
    );

    modport master (
        output pred_req, pred_pc, res_valid, res_taken,
        output pht_rdata, pht_cur_state,
        input  pred_ready, pred_taken, mispredict, res_err,
        input  init_done, pht_read_index, pht_write_index,
        input  pht_load, pht_wdata
    );
endinterface

// File: rtl/gshare_pht_ctrl.sv
// gshare PHT controller: GHR, index hashing, in-flight queue, counter
// updates, mispredict repair and post-reset table sweep.
// Ports: clk, reset_n (sync, active-low), bus (gshare_pht_ctrl_if.slave)
//   pred_req/pred_pc/pred_ready/pred_taken  fetch prediction handshake
//   res_valid/res_taken                     in-order branch resolve
//   mispredict/res_err/init_done            status (registered)
//   pht_read_index/pht_rdata                PHT read port
//   pht_write_index/pht_cur_state/pht_load/pht_wdata  PHT write port
module gshare_pht_ctrl #(
    parameter int         ENTRY      = 8,
    parameter int         HIST       = 8,
    parameter int         PC_W       = 32,
    parameter int         DEPTH      = 4,
    parameter logic [1:0] INIT_STATE = 2'b11
) (
    input logic            clk,
    input logic            reset_n,
    gshare_pht_ctrl_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q;
    logic [ENTRY-1:0] sweep_q;
    logic [HIST-1:0]  ghr_q;
    logic [ENTRY-1:0] q_idx  [DEPTH];
    logic [HIST-1:0]  q_ghr  [DEPTH];
    logic             q_pred [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             mis_q, err_q, done_q;

    logic             run, empty, full;
    logic             res_ok, mis, ready, accept, taken;
    logic [ENTRY-1:0] rd_idx;
    logic [1:0]       upd;

    function automatic logic [HIST-1:0] shl(
        input logic [HIST-1:0] g,
        input logic            b
    );
        logic [HIST:0] t;
        t = {g, b};
        return t[HIST-1:0];
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [1:0] sat(
        input logic [1:0] s,
        input logic       t
    );
        if (t) return (s == 2'b11) ? s : s + 2'b01;
        return (s == 2'b00) ? s : s - 2'b01;
    endfunction

    assign run    = (state_q == RUN);
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_idx = bus.pred_pc[ENTRY+1:2] ^ ENTRY'(ghr_q);
    // a resolve only counts when there is an in-flight entry to retire
    assign res_ok = bus.res_valid & run & ~empty;
    assign mis    = res_ok & (bus.res_taken != q_pred[rd_q]);
    assign ready  = run & ~full & ~mis;
    assign accept = bus.pred_req & ready;
    assign taken  = accept & bus.pht_rdata[1];
    assign upd    = sat(bus.pht_cur_state, bus.res_taken);

    assign bus.pred_ready      = ready;
    assign bus.pred_taken      = taken;
    assign bus.pht_read_index  = rd_idx;
    assign bus.pht_load        = ~run | res_ok;
    assign bus.pht_write_index = run ? q_idx[rd_q] : sweep_q;
    assign bus.pht_wdata       = run ? upd : INIT_STATE;
    assign bus.mispredict      = mis_q;
    assign bus.res_err         = err_q;
    assign bus.init_done       = done_q;

    wire unused_bits = ^{bus.pred_pc[PC_W-1:ENTRY+2],
                         bus.pred_pc[1:0], bus.pht_rdata[0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            sweep_q <= '0;
            ghr_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mis_q <= mis;
            if (bus.res_valid & ~res_ok) err_q <= 1'b1;
            unique case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + ENTRY'(1);
                    if (sweep_q == '1) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mis) begin
                        // repair from the snapshot, drop all younger work
                        ghr_q <= shl(q_ghr[rd_q], bus.res_taken);
                        rd_q  <= wr_q;
                        cnt_q <= '0;
                    end else begin
                        if (accept) begin
                            q_idx[wr_q]  <= rd_idx;
                            q_ghr[wr_q]  <= ghr_q;
                            q_pred[wr_q] <= taken;
                            wr_q         <= inc(wr_q);
                            ghr_q        <= shl(ghr_q, taken);
                        end
                        if (res_ok) rd_q <= inc(rd_q);
                        cnt_q <= cnt_q + CW'(accept) - CW'(res_ok);
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Bench for gshare_pht_ctrl: behavioural model plus directed and random
// stimulus, with a PHT memory behind the controller.
module tb_gshare_pht_ctrl;
    localparam int ENTRY = 8;
    localparam int HIST  = 8;
    localparam int PC_W  = 32;
    localparam int DEPTH = 4;
    localparam int N     = 1 << ENTRY;
    localparam int HMASK = (1 << HIST) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    gshare_pht_ctrl_if #(.ENTRY(ENTRY), .PC_W(PC_W)) bus();

    gshare_pht_ctrl #(
        .ENTRY(ENTRY), .HIST(HIST), .PC_W(PC_W),
        .DEPTH(DEPTH), .INIT_STATE(2'b11)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [1:0] mem [N] = '{default: 2'b00};
    assign bus.pht_rdata     = mem[bus.pht_read_index];
    assign bus.pht_cur_state = mem[bus.pht_write_index];
    always @(posedge clk)
        if (bus.pht_load) mem[bus.pht_write_index] <= bus.pht_wdata;

    typedef struct {
        int idx;
        int ghr;
        bit pred;
    } ent_t;

    ent_t mq[$];
    int   m_pht [N];
    int   m_ghr, m_sweep;
    bit   m_init, m_mis, m_err, m_done;
    bit   c_acc, c_pred, c_res;
    int   c_idx;
    bit   chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    function automatic int sat(input int s, input bit t);
        if (t) return (s == 3) ? 3 : s + 1;
        return (s == 0) ? 0 : s - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h want %0h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int  eidx, ewidx, ewdata;
        bit  eready, eload, bad;
        #1;
        eidx = (int'(bus.pred_pc >> 2) & (N - 1)) ^ m_ghr;
        eready = 0; eload = 0; ewidx = 0; ewdata = 0; c_res = 0;
        if (m_init) begin
            eload = 1; ewidx = m_sweep; ewdata = 3;
        end else begin
            c_res = bus.res_valid && mq.size() > 0;
            bad = c_res && (bus.res_taken != mq[0].pred);
            eready = (mq.size() < DEPTH) && !bad;
            eload = c_res;
            if (c_res) begin
                ewidx  = mq[0].idx;
                ewdata = sat(m_pht[mq[0].idx], bus.res_taken);
            end
        end
        c_acc  = bus.pred_req && eready;
        c_pred = c_acc && (m_pht[eidx] >= 2);
        c_idx  = eidx;
        if (chk_en) begin
            check("pred_ready", bus.pred_ready, eready);
            check("pred_taken", bus.pred_taken, c_pred);
            check("read_index", bus.pht_read_index, eidx);
            check("pht_load", bus.pht_load, eload);
            if (eload) begin
                check("write_index", bus.pht_write_index, ewidx);
                check("pht_wdata", bus.pht_wdata, ewdata);
            end
            check("mispredict", bus.mispredict, m_mis);
            check("res_err", bus.res_err, m_err);
            check("init_done", bus.init_done, m_done);
        end
    end

    always @(posedge clk) begin
        bit   nm;
        int   g0;
        ent_t h;
        if (!reset_n) begin
            m_init = 1; m_sweep = 0; m_ghr = 0; mq.delete();
            m_mis = 0; m_err = 0; m_done = 0;
        end else begin
            nm = 0;
            if (m_init) begin
                m_pht[m_sweep] = 3;
                if (bus.res_valid) m_err = 1;
                m_sweep++;
                if (m_sweep == N) begin
                    m_init = 0; m_done = 1;
                end
            end else begin
                g0 = m_ghr;
                if (c_res) begin
                    h = mq.pop_front();
                    m_pht[h.idx] = sat(m_pht[h.idx], bus.res_taken);
                    if (bus.res_taken != h.pred) begin
                        m_ghr = ((h.ghr << 1) | int'(bus.res_taken)) & HMASK;
                        mq.delete();
                        nm = 1;
                    end
                end else if (bus.res_valid) begin
                    m_err = 1;
                end
                if (c_acc) begin
                    mq.push_back('{c_idx, g0, c_pred});
                    m_ghr = ((g0 << 1) | int'(c_pred)) & HMASK;
                end
            end
            m_mis = nm;
        end
    end

    // rtm: 0/1 literal outcome, 2 = head prediction, 3 = inverted head
    task automatic drive(input bit rq, input int pc, input bit rv,
                         input int rtm);
        @(negedge clk);
        bus.pred_req  = rq;
        bus.pred_pc   = pc;
        bus.res_valid = rv;
        if (rtm < 2) bus.res_taken = rtm[0];
        else if (mq.size() > 0)
            bus.res_taken = (rtm == 2) ? mq[0].pred : !mq[0].pred;
        else bus.res_taken = 1'b0;
        #2;
    endtask

    task automatic pred_at(input int t);
        @(negedge clk);
        bus.pred_req  = 1'b1;
        bus.pred_pc   = ((t ^ m_ghr) & (N - 1)) << 2;
        bus.res_valid = 1'b0;
        #2;
    endtask

    initial begin
        int n;
        int nt_w[4] = '{2, 1, 0, 0};
        int nt_p[4] = '{1, 1, 0, 0};
        reset_n = 1'b0;
        bus.pred_req = 0; bus.pred_pc = 0;
        bus.res_valid = 0; bus.res_taken = 0;
        drive(0, 0, 0, 0);
        chk_en = 1'b1;
        drive(0, 0, 0, 0);
        check("rst_ready", bus.pred_ready, 0);
        check("rst_done", bus.init_done, 0);
        check("rst_widx", bus.pht_write_index, 0);
        check("rst_wdata", bus.pht_wdata, 2'b11);
        check("rst_err", bus.res_err, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (40) drive(0, 0, 0, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 0);
        check("init_err", bus.res_err, 1);
        check("init_load", bus.pht_load, 1);
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        #2;
        check("resweep_widx", bus.pht_write_index, 0);
        check("resweep_err", bus.res_err, 0);
        n = 0;
        while (!bus.init_done && n < 400) begin
            drive(0, 0, 0, 0);
            n++;
        end
        check("sweep_cycles", n, N);

        drive(1, 32'h100, 0, 0);
        check("c1_ready", bus.pred_ready, 1);
        check("c1_taken", bus.pred_taken, 1);
        check("c1_ridx", bus.pht_read_index, 8'h40);
        drive(1, 32'h200, 0, 0);
        check("c2_ridx", bus.pht_read_index, 8'h81);
        drive(0, 0, 1, 1);
        check("sat_up_widx", bus.pht_write_index, 8'h40);
        check("sat_up_wdata", bus.pht_wdata, 2'b11);
        drive(1, 0, 1, 0);
        check("mis_ready", bus.pred_ready, 0);
        check("mis_taken", bus.pred_taken, 0);
        check("mis_wdata", bus.pht_wdata, 2'b10);
        drive(0, 32'h40, 0, 0);
        check("mis_pulse", bus.mispredict, 1);
        check("repair_ridx", bus.pht_read_index, 8'h12);
        drive(1, 32'h40, 0, 0);
        check("mis_pulse_end", bus.mispredict, 0);
        drive(1, 32'h40, 0, 0);
        check("ghr05_ridx", bus.pht_read_index, 8'h15);
        check("ghr05_taken", bus.pred_taken, 1);
        drive(0, 32'h40, 0, 0);
        check("ghr0b_ridx", bus.pht_read_index, 8'h1B);

        drive(1, 32'h1000, 0, 0);
        drive(1, 32'h2004, 0, 0);
        drive(1, 32'h3008, 1, 2);
        check("full_ready", bus.pred_ready, 0);
        check("full_load", bus.pht_load, 1);
        drive(1, 32'h300C, 1, 2);
        check("pop_push_ready", bus.pred_ready, 1);
        check("pop_push_load", bus.pht_load, 1);
        n = 0;
        while (mq.size() > 0 && n < 10) begin
            drive(0, 0, 1, 2);
            n++;
        end

        for (int k = 0; k < 2; k++) begin
            pred_at(8'h5A);
            check("satt_pred", bus.pred_taken, 1);
            drive(0, 0, 1, 1);
            check("satt_wdata", bus.pht_wdata, 2'b11);
        end
        for (int k = 0; k < 4; k++) begin
            pred_at(8'h33);
            check("satn_pred", bus.pred_taken, nt_p[k]);
            drive(0, 0, 1, 0);
            check("satn_widx", bus.pht_write_index, 8'h33);
            check("satn_wdata", bus.pht_wdata, nt_w[k]);
        end
        drive(0, 0, 1, 0);
        check("empty_load", bus.pht_load, 0);
        drive(0, 0, 0, 0);
        check("empty_err", bus.res_err, 1);

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 999) != 0);
            bus.pred_req = ($urandom_range(0, 2) != 0);
            bus.pred_pc  = $urandom;
            if (mq.size() > 0) begin
                bus.res_valid = $urandom_range(0, 1);
                bus.res_taken = ($urandom_range(0, 5) == 0)
                              ? !mq[0].pred : mq[0].pred;
            end else begin
                bus.res_valid = ($urandom_range(0, 39) == 0);
                bus.res_taken = $urandom_range(0, 1);
            end
            #2;
        end
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
